// File: rtl/timer_compare.sv
`default_nettype none
// ============================================================================
// Module   : timer_compare
// Purpose  : Prescaled timer with compare match, free-run/periodic/one-shot
//            modes and sticky irq. Define TIMER_CAPTURE_EN for the capture reg.
// Revision : 1.0
// ============================================================================
module timer_compare #(
  parameter int WIDTH = 32,
  parameter int PRE_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [1:0]       mode,
  input  logic [PRE_W-1:0] prescale,
  input  logic             clr_irq,
`ifdef TIMER_CAPTURE_EN
  input  logic             cap_in,
  output logic [WIDTH-1:0] cap_val,
`endif
  output logic [WIDTH-1:0] count,
  output logic             irq,
  output logic             running
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] M_PERIODIC = 2'b01;
  localparam logic [1:0] M_ONESHOT  = 2'b10;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [PRE_W-1:0] pre_cnt;
  logic [WIDTH-1:0] cmp;
  logic             tick;
  logic             match;

  // A clear in the same cycle swallows the tick entirely (no count, no irq).
  assign tick  = (state == S_RUN) && (pre_cnt >= prescale) && !clr;
  assign match = (count == cmp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (en) state_nxt = S_RUN;
      S_RUN: begin
        if (!en)                                        state_nxt = S_IDLE;
        else if (tick && match && (mode == M_ONESHOT))  state_nxt = S_DONE;
      end
      S_DONE: if (!en) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    running = (state == S_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     pre_cnt <= '0;
    else if (clr || tick)        pre_cnt <= '0;
    else if (state == S_RUN)     pre_cnt <= pre_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr || ((state == S_DONE) && !en)) begin
      count <= '0;
    end else if (tick) begin
      if (match && (mode == M_PERIODIC))
        count <= '0;
      else if (!(match && (mode == M_ONESHOT)))
        count <= count + 1'b1;
    end
  end

  // Compare register updates on the load edge, so a same-cycle match sees the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cmp <= '1;
    else if (load) cmp <= load_val;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                irq <= 1'b0;
    else if (tick && match) irq <= 1'b1;
    else if (clr_irq)       irq <= 1'b0;
  end

`ifdef TIMER_CAPTURE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cap_val <= '0;
    else if (cap_in) cap_val <= count;
  end
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_timer_compare.sv
`default_nettype none
// Scoreboard bench for timer_compare (WIDTH=8, PRE_W=4): each cycle pushes the
// expected {count, irq, running} and pops it once the edge has produced the outputs.
module tb_timer_compare;

  typedef struct packed {
    logic [7:0] ec;
    logic       ei;
    logic       er;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = '0;
  logic [1:0] mode = '0;
  logic [3:0] prescale = '0;
  logic       clr_irq = 1'b0;
  logic [7:0] count;
  logic       irq;
  logic       running;
`ifdef TIMER_CAPTURE_EN
  logic       cap_in = 1'b0;
  logic [7:0] cap_val;
`endif

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  timer_compare #(.WIDTH(8), .PRE_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .mode     (mode),
    .prescale (prescale),
    .clr_irq  (clr_irq),
`ifdef TIMER_CAPTURE_EN
    .cap_in   (cap_in),
    .cap_val  (cap_val),
`endif
    .count    (count),
    .irq      (irq),
    .running  (running)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got errors=%0d, required completion", errors);
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input int c, input logic i, input logic r);
    exp_t e;
    e.ec = 8'(c);
    e.ei = i;
    e.er = r;
    return e;
  endfunction

  task automatic drive(input logic e, input logic c, input logic ci, input logic l, input logic [7:0] lv);
    en = e; clr = c; clr_irq = ci; load = l; load_val = lv;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 8'd0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({count, irq, running} !== 10'b0) begin
      errors++;
      $display("FAIL reset_async: got count=%0d irq=%b running=%b, expected 0/0/0", count, irq, running);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({count, irq, running} !== 10'b0) begin
      errors++;
      $display("FAIL reset_held: got count=%0d irq=%b running=%b, expected 0/0/0", count, irq, running);
    end
    rst = 1'b0;
  endtask

  task automatic test_freerun();
    exp_t e;
    mode = 2'b00; prescale = 4'd0;
    for (int k = 0; k <= 259; k++) begin
      if (k < 259) begin
        drive(1, 0, 0, 0, 8'd0);
        sb.push_back(mk(k % 256, k >= 256, 1'b1));
      end else begin
        drive(0, 1, 1, 0, 8'd0);
        sb.push_back(mk(0, 1'b0, 1'b0));
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({count, irq, running} !== e) begin
        errors++;
        $display("FAIL freerun k=%0d: got count=%0d irq=%b running=%b, expected count=%0d irq=%b running=%b",
                 k, count, irq, running, e.ec, e.ei, e.er);
      end
    end
  endtask

  task automatic test_periodic();
    exp_t e;
    mode = 2'b01; prescale = 4'd3;
    for (int k = 0; k <= 43; k++) begin
      if (k == 0) begin
        drive(0, 1, 1, 1, 8'd9);
        sb.push_back(mk(0, 1'b0, 1'b0));
      end else if (k <= 41) begin
        drive(1, 0, 0, 0, 8'd0);
        sb.push_back(mk((k - 1 < 40) ? (k - 1) / 4 : 0, (k - 1) == 40, 1'b1));
      end else if (k == 42) begin
        drive(1, 0, 1, 0, 8'd0);
        sb.push_back(mk(0, 1'b0, 1'b1));
      end else begin
        drive(0, 1, 0, 0, 8'd0);
        sb.push_back(mk(0, 1'b0, 1'b0));
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({count, irq, running} !== e) begin
        errors++;
        $display("FAIL periodic k=%0d: got count=%0d irq=%b running=%b, expected count=%0d irq=%b running=%b",
                 k, count, irq, running, e.ec, e.ei, e.er);
      end
    end
  endtask

  task automatic test_oneshot();
    exp_t e;
    mode = 2'b10; prescale = 4'd0;
    for (int k = 0; k <= 13; k++) begin
      if (k == 0) begin
        drive(0, 1, 1, 1, 8'd5);
        sb.push_back(mk(0, 1'b0, 1'b0));
      end else if (k <= 8) begin
        drive(1, 0, 0, 0, 8'd0);
        sb.push_back(mk((k - 1 <= 5) ? k - 1 : 5, (k - 1) >= 6, (k - 1) <= 5));
      end else if (k == 9) begin
        drive(0, 0, 0, 0, 8'd0);
        sb.push_back(mk(0, 1'b1, 1'b0));
      end else if (k == 10) begin
        drive(0, 0, 1, 0, 8'd0);
        sb.push_back(mk(0, 1'b0, 1'b0));
      end else if (k <= 12) begin
        drive(1, 0, 0, 0, 8'd0);
        sb.push_back(mk(k - 11, 1'b0, 1'b1));
      end else begin
        drive(0, 1, 0, 0, 8'd0);
        sb.push_back(mk(0, 1'b0, 1'b0));
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({count, irq, running} !== e) begin
        errors++;
        $display("FAIL oneshot k=%0d: got count=%0d irq=%b running=%b, expected count=%0d irq=%b running=%b",
                 k, count, irq, running, e.ec, e.ei, e.er);
      end
    end
  endtask

  // clr_irq on a match cycle, clr on a tick cycle, load coincident with a match.
  task automatic test_priority();
    exp_t e;
    int   pc [14] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 5, 6, 7, 8};
    logic pi [14] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1};
    mode = 2'b00; prescale = 4'd0;
    for (int k = 0; k <= 15; k++) begin
      if (k == 0) begin
        drive(0, 1, 1, 1, 8'd3);
        sb.push_back(mk(0, 1'b0, 1'b0));
      end else if (k <= 14) begin
        drive(1, (k - 1) == 5, (k - 1) == 4 || (k - 1) == 6 || (k - 1) == 10, (k - 1) == 9, 8'd7);
        sb.push_back(mk(pc[k - 1], pi[k - 1], 1'b1));
      end else begin
        drive(0, 1, 0, 0, 8'd0);
        sb.push_back(mk(0, 1'b1, 1'b0));
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({count, irq, running} !== e) begin
        errors++;
        $display("FAIL priority k=%0d: got count=%0d irq=%b running=%b, expected count=%0d irq=%b running=%b",
                 k, count, irq, running, e.ec, e.ei, e.er);
      end
    end
  endtask

  task automatic test_wrap_load();
    exp_t e;
    mode = 2'b01; prescale = 4'd0;
    for (int k = 0; k <= 261; k++) begin
      if (k == 0) begin
        drive(0, 1, 1, 1, 8'd20);
        sb.push_back(mk(0, 1'b0, 1'b0));
      end else begin
        drive(1, 0, 0, (k - 1) == 11, 8'd3);
        sb.push_back(mk((k - 1 < 260) ? (k - 1) % 256 : 0, (k - 1) == 260, 1'b1));
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({count, irq, running} !== e) begin
        errors++;
        $display("FAIL wrap_load k=%0d: got count=%0d irq=%b running=%b, expected count=%0d irq=%b running=%b",
                 k, count, irq, running, e.ec, e.ei, e.er);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1, 0, 0, 0, 8'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({count, irq, running} !== 10'b0) begin
      errors++;
      $display("FAIL async_reset: got count=%0d irq=%b running=%b, expected 0/0/0", count, irq, running);
    end
`ifdef TIMER_CAPTURE_EN
    checks++;
    if (cap_val !== 8'd0) begin
      errors++;
      $display("FAIL async_reset_cap: got cap_val=%0d, expected 0", cap_val);
    end
`endif
    drive(0, 0, 0, 0, 8'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({count, irq, running} !== 10'b0) begin
      errors++;
      $display("FAIL after_reset: got count=%0d irq=%b running=%b, expected 0/0/0", count, irq, running);
    end
  endtask

`ifdef TIMER_CAPTURE_EN
  task automatic test_capture();
    exp_t       e;
    logic [7:0] ecap;
    logic [7:0] cap_q[$];
    mode = 2'b00; prescale = 4'd0;
    for (int k = 0; k <= 45; k++) begin
      drive(1, 0, 0, 0, 8'd0);
      cap_in = (k == 43);
      sb.push_back(mk(k, 1'b0, 1'b1));
      cap_q.push_back((k >= 43) ? 8'd42 : 8'd0);
      @(posedge clk); #1;
      e    = sb.pop_front();
      ecap = cap_q.pop_front();
      checks++;
      if ({count, irq, running} !== e || cap_val !== ecap) begin
        errors++;
        $display("FAIL capture k=%0d: got count=%0d irq=%b running=%b cap_val=%0d, expected count=%0d irq=%b running=%b cap_val=%0d",
                 k, count, irq, running, cap_val, e.ec, e.ei, e.er, ecap);
      end
    end
    cap_in = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_freerun();
    test_periodic();
    test_oneshot();
    test_priority();
    test_wrap_load();
    test_async_reset();
`ifdef TIMER_CAPTURE_EN
    test_capture();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
